// File: rtl/ex_stage.sv
// ex_stage: execute stage feeding the memory stage.
//
// Computes the single-cycle ALU result and registers it together with all
// pass-through control into the EX/MEM pipeline register. Owns the HI/LO
// registers and an iterative multiply/divide unit (shift-add multiply,
// restoring divide) that runs for MD_CYCLES edges while holding off decode.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   valid_in             decode presents a real instruction
//   alu_op               operation select (see localparams below)
//   op_a, op_b, shamt    operands and shift amount
//   store_data           rt value for stores
//   r_we .. insn         control passed through to the memory stage
//   busy                 combinational; multiply/divide unit is running
//   alu_result .. insn_out  registered EX/MEM pipeline outputs
//
// Multiply/divide FSM:
//   state | meaning
//   IDLE  | accepting instructions; HI/LO stable
//   RUN   | one multiply/divide iteration per edge; outputs carry bubbles

module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [4:0]  alu_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  shamt,
    input  logic [31:0] store_data,
    input  logic        r_we,
    input  logic [4:0]  rd_loc,
    input  logic [1:0]  rw_d,
    input  logic [1:0]  access_size,
    input  logic [1:0]  store_size,
    input  logic        read_not_write,
    input  logic        mem_enable,
    input  logic        mem_sign_extend,
    input  logic [31:0] pc,
    input  logic [31:0] insn,
    output logic        busy,
    output logic [31:0] alu_result,
    output logic [31:0] store_data_out,
    output logic        r_we_out,
    output logic [4:0]  rd_loc_out,
    output logic [1:0]  rw_d_out,
    output logic [1:0]  access_size_out,
    output logic [1:0]  store_size_out,
    output logic        read_not_write_out,
    output logic        mem_enable_out,
    output logic        mem_sign_extend_out,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_MULTU = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_MFHI  = 5'd16;
    localparam logic [4:0] OP_MFLO  = 5'd17;
    localparam logic [4:0] OP_MTHI  = 5'd18;
    localparam logic [4:0] OP_MTLO  = 5'd19;

    localparam logic [4:0] LAST_ITER = 5'(MD_CYCLES - 1);

    typedef enum logic [0:0] {IDLE, RUN} md_state_t;

    md_state_t   state;
    logic [4:0]  count;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Iteration registers: {md_hi, md_lo} is the product/shift register for
    // multiply and {remainder, quotient} for divide; md_opnd holds the
    // multiplicand or divisor magnitude.
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic [31:0] md_opnd;
    logic        md_is_div;
    logic        md_neg_lo;
    logic        md_neg_hi;

    logic        accept;
    logic        is_md_op;
    logic        is_signed_md;
    logic        is_div_op;
    logic        no_wb;
    logic [31:0] result;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] mul_fix;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;

    assign busy     = (state != IDLE);
    assign accept   = valid_in && (state == IDLE);
    assign is_md_op = (alu_op == OP_MULT) || (alu_op == OP_MULTU) ||
                      (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
    assign is_div_op    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign is_signed_md = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign no_wb = is_md_op || (alu_op == OP_MTHI) || (alu_op == OP_MTLO);

    assign a_mag = (is_signed_md && op_a[31]) ? (~op_a + 32'd1) : op_a;
    assign b_mag = (is_signed_md && op_b[31]) ? (~op_b + 32'd1) : op_b;

    always_comb begin
        result = 32'd0;
        case (alu_op)
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_NOR:  result = ~(op_a | op_b);
            OP_SLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: result = {31'd0, op_a < op_b};
            OP_SLL:  result = op_b << shamt;
            OP_SRL:  result = op_b >> shamt;
            OP_SRA:  result = $unsigned($signed(op_b) >>> shamt);
            OP_LUI:  result = {op_b[15:0], 16'h0000};
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = 32'd0;
        endcase
    end

    // One iteration step of each algorithm.
    assign mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_opnd} : 33'd0);
    assign div_shift = {md_hi, md_lo[31]};
    assign div_diff  = div_shift - {1'b0, md_opnd};

    always_comb begin
        step_hi = 32'd0;
        step_lo = 32'd0;
        if (md_is_div) begin
            // A non-negative trial difference means the divisor fits.
            if (!div_diff[32]) begin
                step_hi = div_diff[31:0];
                step_lo = {md_lo[30:0], 1'b1};
            end else begin
                step_hi = div_shift[31:0];
                step_lo = {md_lo[30:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], md_lo[31:1]};
        end
    end

    // Sign correction on the final step. A zero divisor leaves the quotient
    // all ones and the remainder equal to |op_a|; restoring op_a's sign on
    // the remainder makes HI equal op_a for both DIV and DIVU.
    assign mul_fix = md_neg_lo ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};

    always_comb begin
        fin_hi = mul_fix[63:32];
        fin_lo = mul_fix[31:0];
        if (md_is_div) begin
            fin_lo = md_neg_lo ? (~step_lo + 32'd1) : step_lo;
            fin_hi = md_neg_hi ? (~step_hi + 32'd1) : step_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            md_hi     <= 32'd0;
            md_lo     <= 32'd0;
            md_opnd   <= 32'd0;
            md_is_div <= 1'b0;
            md_neg_lo <= 1'b0;
            md_neg_hi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (alu_op == OP_MTHI) hi_q <= op_a;
                        if (alu_op == OP_MTLO) lo_q <= op_a;
                        if (is_md_op) begin
                            state     <= RUN;
                            count     <= 5'd0;
                            md_hi     <= 32'd0;
                            md_is_div <= is_div_op;
                            if (is_div_op) begin
                                md_lo     <= a_mag;
                                md_opnd   <= b_mag;
                                md_neg_lo <= is_signed_md && (op_a[31] ^ op_b[31]) &&
                                             (op_b != 32'd0);
                                md_neg_hi <= is_signed_md && op_a[31];
                            end else begin
                                md_lo     <= b_mag;
                                md_opnd   <= a_mag;
                                md_neg_lo <= is_signed_md && (op_a[31] ^ op_b[31]);
                                md_neg_hi <= 1'b0;
                            end
                        end
                    end
                end
                RUN: begin
                    md_hi <= step_hi;
                    md_lo <= step_lo;
                    count <= count + 5'd1;
                    if (count == LAST_ITER) begin
                        hi_q  <= fin_hi;
                        lo_q  <= fin_lo;
                        count <= 5'd0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result          <= 32'd0;
            store_data_out      <= 32'd0;
            r_we_out            <= 1'b0;
            rd_loc_out          <= 5'd0;
            rw_d_out            <= 2'd0;
            access_size_out     <= 2'd0;
            store_size_out      <= 2'd0;
            read_not_write_out  <= 1'b0;
            mem_enable_out      <= 1'b0;
            mem_sign_extend_out <= 1'b0;
            pc_out              <= 32'd0;
            insn_out            <= 32'd0;
        end else if (accept) begin
            alu_result          <= result;
            store_data_out      <= store_data;
            r_we_out            <= r_we && !no_wb;
            rd_loc_out          <= rd_loc;
            rw_d_out            <= rw_d;
            access_size_out     <= access_size;
            store_size_out      <= store_size;
            read_not_write_out  <= read_not_write;
            mem_enable_out      <= mem_enable;
            mem_sign_extend_out <= mem_sign_extend;
            pc_out              <= pc;
            insn_out            <= insn;
        end else begin
            // Bubble: kill anything with side effects, hold the rest.
            r_we_out       <= 1'b0;
            mem_enable_out <= 1'b0;
            insn_out       <= 32'd0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with hand-computed
// expected values. Inputs change on the falling edge; outputs are checked
// on the following falling edge.

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [4:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] store_data;
    logic        r_we;
    logic [4:0]  rd_loc;
    logic [1:0]  rw_d;
    logic [1:0]  access_size;
    logic [1:0]  store_size;
    logic        read_not_write;
    logic        mem_enable;
    logic        mem_sign_extend;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        busy;
    logic [31:0] alu_result;
    logic [31:0] store_data_out;
    logic        r_we_out;
    logic [4:0]  rd_loc_out;
    logic [1:0]  rw_d_out;
    logic [1:0]  access_size_out;
    logic [1:0]  store_size_out;
    logic        read_not_write_out;
    logic        mem_enable_out;
    logic        mem_sign_extend_out;
    logic [31:0] pc_out;
    logic [31:0] insn_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_stage #(.MD_CYCLES(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .valid_in            (valid_in),
        .alu_op              (alu_op),
        .op_a                (op_a),
        .op_b                (op_b),
        .shamt               (shamt),
        .store_data          (store_data),
        .r_we                (r_we),
        .rd_loc              (rd_loc),
        .rw_d                (rw_d),
        .access_size         (access_size),
        .store_size          (store_size),
        .read_not_write      (read_not_write),
        .mem_enable          (mem_enable),
        .mem_sign_extend     (mem_sign_extend),
        .pc                  (pc),
        .insn                (insn),
        .busy                (busy),
        .alu_result          (alu_result),
        .store_data_out      (store_data_out),
        .r_we_out            (r_we_out),
        .rd_loc_out          (rd_loc_out),
        .rw_d_out            (rw_d_out),
        .access_size_out     (access_size_out),
        .store_size_out      (store_size_out),
        .read_not_write_out  (read_not_write_out),
        .mem_enable_out      (mem_enable_out),
        .mem_sign_extend_out (mem_sign_extend_out),
        .pc_out              (pc_out),
        .insn_out            (insn_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        valid_in = 1'b1;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        shamt    = sh;
        r_we     = 1'b1;
        rd_loc   = 5'd3;
        insn     = 32'h0000_0100 | {27'd0, op};
        mem_enable = 1'b0;
    endtask

    task automatic alu_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        drive(op, a, b, sh);
        tick;
        check(tag, {32'd0, alu_result}, {32'd0, exp});
    endtask

    // Issue a multiply/divide, hold MFLO during busy, then read MFHI.
    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int busy_cyc;
        int bad_bubble;
        drive(op, a, b, 5'd0);
        tick;
        check({tag, "_rwe_e0"}, {63'd0, r_we_out}, 64'd0);
        drive(5'd17, 32'd0, 32'd0, 5'd0);
        busy_cyc   = 0;
        bad_bubble = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cyc++;
            if (r_we_out !== 1'b0) bad_bubble++;
            tick;
        end
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd32);
        check({tag, "_bubble_rwe"}, 64'(bad_bubble), 64'd0);
        tick;
        check({tag, "_lo"}, {32'd0, alu_result}, {32'd0, exp_lo});
        drive(5'd16, 32'd0, 32'd0, 5'd0);
        tick;
        check({tag, "_hi"}, {32'd0, alu_result}, {32'd0, exp_hi});
        valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; alu_op = 5'd0; op_a = 32'd0; op_b = 32'd0; shamt = 5'd0;
        store_data = 32'd0; r_we = 1'b0; rd_loc = 5'd0; rw_d = 2'd0; access_size = 2'd0;
        store_size = 2'd0; read_not_write = 1'b0; mem_enable = 1'b0; mem_sign_extend = 1'b0;
        pc = 32'd0; insn = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_alu", {32'd0, alu_result}, 64'd0);
        check("rst_pc_insn", {pc_out, insn_out}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD wrap, signed/unsigned compare
        drive(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        tick;
        check("add_wrap", {32'd0, alu_result}, 64'h8000_0000);
        check("add_rwe", {63'd0, r_we_out}, 64'd1);
        alu_vec("slt", 5'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        drive(5'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);
        r_we = 1'b0;
        tick;
        check("sltu", {32'd0, alu_result}, 64'd0);
        check("sltu_rwe", {63'd0, r_we_out}, 64'd0);

        alu_vec("sub", 5'd1, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
        alu_vec("nor", 5'd5, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'hF0F0_FF0F);
        alu_vec("sll", 5'd8, 32'd0, 32'd1, 5'd31, 32'h8000_0000);
        alu_vec("srl", 5'd9, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000);
        alu_vec("sra", 5'd10, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
        alu_vec("lui", 5'd11, 32'd0, 32'hABCD_1234, 5'd0, 32'h1234_0000);
        alu_vec("xor", 5'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'hF00F_F00F);

        drive(5'd20, 32'd5, 32'd6, 5'd0);
        tick;
        check("unused_res", {32'd0, alu_result}, 64'd0);
        check("unused_ctl", {58'd0, r_we_out, rd_loc_out}, {58'd0, 1'b1, 5'd3});

        // Multiply/divide
        run_md("mult", 5'd12, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("div", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", 5'd15, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_md("multu", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("divovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md("div_neg0", 5'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // MTHI, then reset in the middle of a MULT
        drive(5'd18, 32'h1234, 32'd0, 5'd0);
        tick;
        check("mthi_rwe", {63'd0, r_we_out}, 64'd0);
        alu_vec("mfhi_1234", 5'd16, 32'd0, 32'd0, 5'd0, 32'h1234);
        drive(5'd12, 32'd2, 32'd3, 5'd0);
        tick;
        drive(5'd16, 32'd0, 32'd0, 5'd0);
        repeat (10) tick;
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_out", {alu_result, pc_out | insn_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick;
        check("mfhi_after_rst", {32'd0, alu_result}, 64'd0);
        check("mfhi_after_rst_rwe", {63'd0, r_we_out}, 64'd1);

        // Load: full pass-through
        drive(5'd0, 32'h1000, 32'd4, 5'd0);
        pc = 32'h100; insn = 32'h8C43_0004; store_data = 32'hDEAD_BEEF; rd_loc = 5'd9;
        rw_d = 2'd2; access_size = 2'd2; store_size = 2'd2; read_not_write = 1'b1;
        mem_enable = 1'b1; mem_sign_extend = 1'b1;
        tick;
        check("ld_addr", {32'd0, alu_result}, 64'h1004);
        check("ld_pc_insn", {pc_out, insn_out}, {32'h100, 32'h8C43_0004});
        check("ld_sdata", {32'd0, store_data_out}, 64'hDEAD_BEEF);
        check("ld_ctl", {51'd0, r_we_out, rd_loc_out, rw_d_out, access_size_out, store_size_out,
                         read_not_write_out, mem_enable_out, mem_sign_extend_out},
              {51'd0, 1'b1, 5'd9, 2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1});

        // Bubble: kill side effects, hold the rest
        valid_in = 1'b0;
        tick;
        check("bub_kill", {31'd0, r_we_out, mem_enable_out, insn_out}, 64'd0);
        check("bub_hold", {alu_result, pc_out}, {32'h1004, 32'h100});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage, directly upstream of the memory stage. It consumes decoded operands and control, computes the ALU result, and registers the result plus all pass-through control into the pipeline register that feeds the memory stage.
- It owns the HI/LO registers and an iterative 32-cycle multiply/divide unit.
- While that unit runs, `busy` stalls the decode stage and the outputs carry bubbles.

Parameters:
- MD_CYCLES, 32, number of iteration cycles for MULT/MULTU/DIV/DIVU (fixed at 32; kept as a parameter for documentation only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  decode presents a real instruction
- alu_op  in  5  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 MULT, 13 MULTU, 14 DIV, 15 DIVU, 16 MFHI, 17 MFLO, 18 MTHI, 19 MTLO, others produce result 0
- op_a  in  32  operand A (rs, forwarded)
- op_b  in  32  operand B (rt or immediate)
- shamt  in  5  shift amount; decode supplies rs[4:0] for variable shifts
- store_data  in  32  rt value for stores
- r_we, rd_loc[4:0], rw_d[2], access_size[2], store_size[2], read_not_write, mem_enable, mem_sign_extend, pc[32], insn[32]  in  control to pass to the memory stage
- busy  out  1  combinational; high while the multiply/divide FSM is not IDLE
- alu_result  out  32  registered; drives the memory-stage address
- store_data_out  out  32  registered
- r_we_out, rd_loc_out, rw_d_out, access_size_out, store_size_out, read_not_write_out, mem_enable_out, mem_sign_extend_out, pc_out, insn_out  out  registered copies

Behaviour:
- Reset (async, rst=1):
  - All registered outputs are 0. HI=0, LO=0.
  - FSM goes to IDLE, iteration counter is 0.
  - busy=0 while reset is held.
- Accept: an instruction is accepted on a rising edge when valid_in=1 and the FSM is IDLE.
- Single-cycle ops:
  - On accept, every output register loads the computed result and the input control in the same edge. Latency is 1 cycle.
  - ADD/SUB wrap modulo 2^32 with no overflow trap.
  - SLT is signed and SLTU is unsigned; both produce 0 or 1.
  - SLL/SRL/SRA shift op_b by shamt.
  - LUI produces {op_b[15:0], 16'h0}.
- Bubbles: when valid_in=0, or the FSM is not IDLE, the outputs load a bubble on each edge.
  - Bubble: r_we_out=0, mem_enable_out=0, insn_out=0.
  - All other outputs hold their previous value.
- MFHI/MFLO: result is the current HI/LO. They can never observe an in-flight value because issue is blocked while busy.
- MTHI/MTLO: on accept, HI (or LO) takes op_a and r_we_out is forced to 0.
- MULT/MULTU/DIV/DIVU:
  - Accept edge (E0): operands are latched and r_we_out is forced to 0 (the instruction leaves as a non-writing op). FSM goes IDLE -> RUN with count=0.
  - In RUN, one shift-add (multiply) or restoring-subtract (divide) step runs per edge.
  - The edge where count=31 (E32) writes HI/LO and returns to IDLE.
  - busy is high for exactly 32 cycles (E0 to E32). Decode holds its inputs unchanged for that time.
- Signed MULT/DIV: the unit iterates on magnitudes, then applies signs.
  - MULT: the 64-bit product is negated when the operand signs differ.
  - DIV: the quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=op_a. No exception.
- Results: MULT/MULTU put HI=product[63:32], LO=product[31:0]. DIV/DIVU put LO=quotient, HI=remainder.
- Reset mid-operation: the FSM aborts immediately, HI/LO clear to 0, and busy drops while rst is high. The aborted operation leaves no effect.
- Back-to-back: MFLO presented while busy is accepted on the edge after E32 and returns the new LO.
- valid_in=1 with an unused alu_op: result is 0 and the control passes through unchanged.

Test Plan:
- ADD 0x7FFFFFFF+1, then SLT(-1,1), then SLTU(-1,1) -> alu_result 0x80000000, then 1, then 0, each one edge after accept; r_we_out follows the input.
- MULT op_a=-3, op_b=5, followed by a held MFLO then MFHI -> busy high for exactly 32 cycles; bubbles with r_we_out=0 during that time; MFLO result 0xFFFFFFF1, MFHI result 0xFFFFFFFF.
- DIV -7/2 then DIVU 7/0 -> first gives LO=0xFFFFFFFD, HI=0xFFFFFFFF; second gives LO=0xFFFFFFFF, HI=7.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- MTHI 0x1234, then MULT 2*3 with rst pulsed at iteration 10, then MFHI -> busy drops on rst and all outputs are 0; a fresh MFHI returns 0.
- Load with pc=0x100, store_size=2, mem_sign_extend=1, op_a=0x1000, op_b=4 (ADD) -> alu_result 0x1004; all pass-through outputs are equal to their inputs one edge later.
